// File: rtl/gate_reducer_pkg.sv
// +-------------------------------------------------------------------------+
// | gate_reducer_pkg : shared types and helpers for the N-ary gate reducer  |
// | Revision 1.0                                                            |
// +-------------------------------------------------------------------------+
`default_nettype none

package gate_reducer_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam logic [2:0] OP_CODE_MAX = 3'd5;

  function automatic logic is_legal(input logic [2:0] code);
    return code <= OP_CODE_MAX;
  endfunction

  // Explicit decode keeps illegal codes from ever being cast into op_e.
  function automatic op_e to_op(input logic [2:0] code);
    op_e op;
    case (code)
      3'd1:    op = OP_OR;
      3'd2:    op = OP_XOR;
      3'd3:    op = OP_NAND;
      3'd4:    op = OP_NOR;
      3'd5:    op = OP_XNOR;
      default: op = OP_AND;
    endcase
    return op;
  endfunction

  function automatic logic is_inverted(input op_e op);
    return (op == OP_NAND) || (op == OP_NOR) || (op == OP_XNOR);
  endfunction

  function automatic op_e base_op(input op_e op);
    op_e b;
    case (op)
      OP_OR, OP_NOR:   b = OP_OR;
      OP_XOR, OP_XNOR: b = OP_XOR;
      default:         b = OP_AND;
    endcase
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gate_fold_lane.sv
// +-------------------------------------------------------------------------+
// | gate_fold_lane : combinational WIDTH-bit AND/OR/XOR combiner            |
// | Revision 1.0                                                            |
// +-------------------------------------------------------------------------+
`default_nettype none

module gate_fold_lane
  import gate_reducer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);

  always_comb begin
    y_o = a_i & b_i;
    case (op_i)
      OP_OR:   y_o = a_i | b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      default: y_o = a_i & b_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/nary_gate_reducer.sv
// +-------------------------------------------------------------------------+
// | nary_gate_reducer : streams operands in and folds them under one gate   |
// | function, presenting one registered result per transaction.            |
// | Revision 1.0                                                            |
// +-------------------------------------------------------------------------+
`default_nettype none

module nary_gate_reducer
  import gate_reducer_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_OPS = 16,
  parameter int CNT_W   = $clog2(MAX_OPS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_op,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_err
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  op_e              op_q, op_d;
  logic             illegal_q, illegal_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_err_q, out_err_d;

  logic             beat;
  logic             first;
  logic             cnt_sat;
  op_e              eff_op;
  logic             eff_illegal;
  logic             eff_ovf;
  logic [CNT_W-1:0] eff_cnt;
  logic [WIDTH-1:0] fold_y;
  logic [WIDTH-1:0] eff_acc;
  logic [WIDTH-1:0] result;

  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_err   = out_err_q;

  assign beat    = in_valid & in_ready;
  assign first   = (state_q == IDLE);
  assign cnt_sat = (cnt_q == CNT_W'(MAX_OPS));

  // in_op only matters on the opening beat of a transaction.
  assign eff_op      = first ? to_op(in_op) : op_q;
  assign eff_illegal = first ? ~is_legal(in_op) : illegal_q;
  assign eff_ovf     = first ? 1'b0 : (ovf_q | cnt_sat);
  assign eff_cnt     = first ? CNT_W'(1) : (cnt_sat ? cnt_q : cnt_q + CNT_W'(1));

  gate_fold_lane #(
    .WIDTH (WIDTH)
  ) u_fold (
    .op_i (base_op(op_q)),
    .a_i  (acc_q),
    .b_i  (in_data),
    .y_o  (fold_y)
  );

  assign eff_acc = first ? in_data : fold_y;

  // Inversion is applied once to the completed fold, never per beat.
  assign result = eff_illegal ? '0 : (is_inverted(eff_op) ? ~eff_acc : eff_acc);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    op_d        = op_q;
    illegal_d   = illegal_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_err_d   = out_err_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (beat) begin
          acc_d     = eff_acc;
          op_d      = eff_op;
          illegal_d = eff_illegal;
          ovf_d     = eff_ovf;
          cnt_d     = eff_cnt;
          if (in_last) begin
            state_d     = HOLD;
            out_data_d  = result;
            out_count_d = eff_cnt;
            out_err_d   = eff_illegal | eff_ovf;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d   = IDLE;
          cnt_d     = '0;
          ovf_d     = 1'b0;
          illegal_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      op_q        <= OP_AND;
      illegal_q   <= 1'b0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      op_q        <= op_d;
      illegal_q   <= illegal_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_err_q   <= out_err_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_nary_gate_reducer.sv
// +-------------------------------------------------------------------------+
// | tb_nary_gate_reducer : directed vector bench for nary_gate_reducer      |
// | Revision 1.0                                                            |
// +-------------------------------------------------------------------------+
`default_nettype none

module tb_nary_gate_reducer;

  localparam int WIDTH   = 8;
  localparam int MAX_OPS = 4;
  localparam int CNT_W   = $clog2(MAX_OPS + 1);
  localparam int NVEC    = 12;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [2:0]       in_op;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_err;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [2:0]       op;
    logic [3:0]       n;
    logic [7:0][7:0]  d;
    logic [7:0]       exp_data;
    logic [2:0]       exp_cnt;
    logic             exp_err;
  } vec_t;

  vec_t vecs [NVEC];

  // Truth tables indexed by {a,b}: AND, OR, XOR, NAND, NOR, XNOR.
  logic [3:0] tt [6];

  nary_gate_reducer #(
    .WIDTH   (WIDTH),
    .MAX_OPS (MAX_OPS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_op     (in_op),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0][7:0] pk(input logic [7:0] b0, input logic [7:0] b1 = 8'h00,
                                         input logic [7:0] b2 = 8'h00, input logic [7:0] b3 = 8'h00,
                                         input logic [7:0] b4 = 8'h00);
    logic [7:0][7:0] r;
    r = '0;
    r[0] = b0; r[1] = b1; r[2] = b2; r[3] = b3; r[4] = b4;
    return r;
  endfunction

  function automatic vec_t mkv(input logic [2:0] op, input logic [3:0] n, input logic [7:0][7:0] d,
                               input logic [7:0] ed, input logic [2:0] ec, input logic ee);
    vec_t v;
    v.op = op; v.n = n; v.d = d; v.exp_data = ed; v.exp_cnt = ec; v.exp_err = ee;
    return v;
  endfunction

  // Later beats carry op code 7 to show in_op is ignored after the first beat.
  task automatic send_beats(input string tag, input logic [2:0] op, input int n,
                            input logic [7:0][7:0] d, input bit gaps, input bit close);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d[i];
      in_op    = (i == 0) ? op : 3'd7;
      in_last  = close && (i == n - 1);
      begin
        int t = 0;
        while (!in_ready && t < 20) begin
          @(negedge clk);
          t++;
        end
        if (t == 20) check({tag, " ready_timeout"}, 32'd0, 32'd1);
      end
      @(posedge clk);
    end
  endtask

  task automatic finish_txn(input string tag, input logic [7:0] ed, input logic [2:0] ec,
                            input logic ee, input bit gaps);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check({tag, " valid"}, out_valid, 1);
    check({tag, " data"}, out_data, ed);
    check({tag, " count"}, out_count, ec);
    check({tag, " err"}, out_err, ee);
    check({tag, " in_ready_hold"}, in_ready, 0);
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check({tag, " valid_wait"}, out_valid, 1);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " valid_drop"}, out_valid, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_op     = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    vecs[0]  = mkv(3'd3, 4'd2, pk(8'hF0, 8'h3C),                      8'hCF, 3'd2, 1'b0);
    vecs[1]  = mkv(3'd5, 4'd4, pk(8'h01, 8'h02, 8'h04, 8'h08),        8'hF0, 3'd4, 1'b0);
    vecs[2]  = mkv(3'd4, 4'd1, pk(8'hA5),                              8'h5A, 3'd1, 1'b0);
    vecs[3]  = mkv(3'd1, 4'd1, pk(8'hA5),                              8'hA5, 3'd1, 1'b0);
    vecs[4]  = mkv(3'd0, 4'd5, pk(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF), 8'hFF, 3'd4, 1'b1);
    vecs[5]  = mkv(3'd6, 4'd2, pk(8'h12, 8'h34),                      8'h00, 3'd2, 1'b1);
    vecs[6]  = mkv(3'd7, 4'd1, pk(8'hFF),                              8'h00, 3'd1, 1'b1);
    vecs[7]  = mkv(3'd0, 4'd3, pk(8'hF0, 8'h3C, 8'hFF),                8'h30, 3'd3, 1'b0);
    vecs[8]  = mkv(3'd2, 4'd5, pk(8'h01, 8'h02, 8'h04, 8'h08, 8'h10), 8'h1F, 3'd4, 1'b1);
    vecs[9]  = mkv(3'd4, 4'd2, pk(8'h00, 8'h00),                      8'hFF, 3'd2, 1'b0);
    vecs[10] = mkv(3'd5, 4'd1, pk(8'h3C),                              8'hC3, 3'd1, 1'b0);
    vecs[11] = mkv(3'd1, 4'd4, pk(8'h01, 8'h80, 8'h00, 8'h10),        8'h91, 3'd4, 1'b0);

    tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0110;
    tt[3] = 4'b0111; tt[4] = 4'b0001; tt[5] = 4'b1001;

    repeat (3) @(negedge clk);
    check("reset out_valid", out_valid, 0);
    check("reset out_data", out_data, 0);
    check("reset out_count", out_count, 0);
    check("reset out_err", out_err, 0);
    check("reset in_ready", in_ready, 1);
    rst_n = 1'b1;

    for (int k = 0; k < NVEC; k++) begin
      string tag;
      tag = $sformatf("vec%0d", k);
      send_beats(tag, vecs[k].op, int'(vecs[k].n), vecs[k].d, k[0], 1'b1);
      finish_txn(tag, vecs[k].exp_data, vecs[k].exp_cnt, vecs[k].exp_err, k[0]);
    end

    // Backpressure: result held and beats refused while the consumer stalls.
    send_beats("bp", 3'd0, 2, pk(8'hC3, 8'h81), 1'b0, 1'b1);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data  = 8'h55;
      in_op    = 3'd1;
      in_last  = 1'b1;
      check("bp in_ready", in_ready, 0);
      check("bp out_valid", out_valid, 1);
      check("bp out_data", out_data, 8'h81);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp released", out_valid, 0);
    send_beats("bp_next", 3'd2, 2, pk(8'h0F, 8'hFF), 1'b0, 1'b1);
    finish_txn("bp_next", 8'hF0, 3'd2, 1'b0, 1'b0);

    // Asynchronous abort in the middle of a transaction.
    send_beats("abort", 3'd0, 2, pk(8'h77, 8'h33), 1'b0, 1'b0);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("abort out_valid", out_valid, 0);
    check("abort out_data", out_data, 0);
    check("abort out_count", out_count, 0);
    check("abort out_err", out_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send_beats("post_abort", 3'd3, 2, pk(8'hFF, 8'hFF), 1'b0, 1'b1);
    finish_txn("post_abort", 8'h00, 3'd2, 1'b0, 1'b0);

    // Every 2-operand truth-table row for every legal op, with random gaps.
    for (int op = 0; op < 6; op++) begin
      for (int ab = 0; ab < 4; ab++) begin
        logic a, b, e;
        string tag;
        a = ab[1];
        b = ab[0];
        e = tt[op][ab];
        tag = $sformatf("tt op%0d a%0d b%0d", op, a, b);
        send_beats(tag, 3'(op), 2, pk({8{a}}, {8{b}}), 1'b1, 1'b1);
        finish_txn(tag, {8{e}}, 3'd2, 1'b0, 1'b1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
